// File: rtl/vector_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vector_pkg : shared widths and entry type for the vector ID/EX stage  |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package vector_pkg;

  localparam int LANE_W = 8;
  localparam int LANES  = 6;
  localparam int N      = LANES * LANE_W;
  localparam int REG_AW = 3;

  typedef logic [4:0]        alu_ctrl_t;
  typedef logic [REG_AW-1:0] vreg_t;
  typedef logic [N-1:0]      vec_t;

  typedef struct packed {
    alu_ctrl_t ctrl;
    vec_t      a;
    vec_t      b;
    vreg_t     rs1;
    vreg_t     rs2;
    vreg_t     rd;
    logic      we;
    logic      valid;
  } id_ex_entry_t;

endpackage
`default_nettype wire

// File: rtl/vector_operand_fwd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vector_operand_fwd : replaces an entry's operands with writeback data |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
module vector_operand_fwd
  import vector_pkg::*;
(
  input  id_ex_entry_t entry_in,
  input  logic         fwd_valid,
  input  vreg_t        fwd_rd,
  input  vec_t         fwd_data,
  output id_ex_entry_t entry_out
);

  always_comb begin
    entry_out = entry_in;
    if (fwd_valid && (entry_in.rs1 == fwd_rd)) entry_out.a = fwd_data;
    if (fwd_valid && (entry_in.rs2 == fwd_rd)) entry_out.b = fwd_data;
  end

endmodule
`default_nettype wire

// File: rtl/vector_id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vector_id_ex_stage : 2-entry skid buffer with operand forwarding      |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
module vector_id_ex_stage #(
  parameter int N      = 48,
  parameter int LANE_W = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_alu_ctrl,
  input  logic [N-1:0]      in_src_a,
  input  logic [N-1:0]      in_src_b,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_we,
  input  logic              fwd_valid,
  input  logic [REG_AW-1:0] fwd_rd,
  input  logic [N-1:0]      fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        alu_ctrl,
  output logic [N-1:0]      src_A,
  output logic [N-1:0]      src_B,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_we
);

  import vector_pkg::*;

  if (N != vector_pkg::LANES * LANE_W) begin : g_width_check
    $error("vector_id_ex_stage: N must equal LANES*LANE_W");
  end

  id_ex_entry_t r_main, r_skid;
  id_ex_entry_t w_in, w_in_f, w_main_f, w_skid_f;
  logic         w_accept, w_xfer;

  always_comb begin
    w_in       = '0;
    w_in.ctrl  = in_alu_ctrl;
    w_in.a     = in_src_a;
    w_in.b     = in_src_b;
    w_in.rs1   = in_rs1;
    w_in.rs2   = in_rs2;
    w_in.rd    = in_rd;
    w_in.we    = in_we;
    w_in.valid = in_valid;
  end

  vector_operand_fwd u_fwd_in (
    .entry_in (w_in),   .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data (fwd_data), .entry_out(w_in_f)
  );
  vector_operand_fwd u_fwd_main (
    .entry_in (r_main), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data (fwd_data), .entry_out(w_main_f)
  );
  vector_operand_fwd u_fwd_skid (
    .entry_in (r_skid), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data (fwd_data), .entry_out(w_skid_f)
  );

  assign in_ready = !r_skid.valid;
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_main.valid && out_ready;

  // Skid can only be occupied while main is; an accept never coincides with a full skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (flush) begin
      r_main.valid <= 1'b0;
      r_skid.valid <= 1'b0;
    end else if (!r_main.valid || w_xfer) begin
      if (r_skid.valid) begin
        r_main       <= w_skid_f;
        r_skid.valid <= 1'b0;
      end else if (w_accept) begin
        r_main <= w_in_f;
      end else begin
        r_main.valid <= 1'b0;
      end
    end else begin
      r_main <= w_main_f;
      if (w_accept)          r_skid <= w_in_f;
      else if (r_skid.valid) r_skid <= w_skid_f;
    end
  end

  assign out_valid = r_main.valid;
  assign alu_ctrl  = r_main.ctrl;
  assign src_A     = r_main.a;
  assign src_B     = r_main.b;
  assign out_rd    = r_main.rd;
  assign out_we    = r_main.we;

endmodule
`default_nettype wire

// File: tb/tb_vector_id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vector_id_ex_stage : directed and randomized checks of the stage   |
// | Revision              : 1.0                                           |
// +----------------------------------------------------------------------+
module tb_vector_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_alu_ctrl = '0;
  logic [47:0] in_src_a = '0, in_src_b = '0;
  logic [2:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic        in_we = 1'b0;
  logic        fwd_valid = 1'b0;
  logic [2:0]  fwd_rd = '0;
  logic [47:0] fwd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  alu_ctrl;
  logic [47:0] src_A, src_B;
  logic [2:0]  out_rd;
  logic        out_we;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  vector_id_ex_stage #(.N(48), .LANE_W(8), .REG_AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_ctrl(in_alu_ctrl),
    .in_src_a(in_src_a), .in_src_b(in_src_b),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_we(in_we),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .src_A(src_A), .src_B(src_B), .out_rd(out_rd), .out_we(out_we)
  );

  // Reference: an in-order queue of at most two pending operations.
  typedef struct {
    logic [4:0]  ctrl;
    logic [47:0] a, b;
    logic [2:0]  rs1, rs2, rd;
    logic        we;
  } op_t;
  op_t q[$];

  task automatic drive_in(input logic v, input logic [4:0] c, input logic [47:0] a,
                          input logic [47:0] b, input logic [2:0] r1, input logic [2:0] r2,
                          input logic [2:0] rd, input logic we);
    in_valid = v; in_alu_ctrl = c; in_src_a = a; in_src_b = b;
    in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_we = we;
  endtask

  // Advance the model by one clock using the inputs currently driven, then move to the next negedge.
  task automatic tick();
    op_t n;
    if (flush) begin
      q.delete();
    end else begin
      bit acc;
      acc = in_valid && (q.size() < 2);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (fwd_valid) begin
        foreach (q[i]) begin
          if (q[i].rs1 == fwd_rd) q[i].a = fwd_data;
          if (q[i].rs2 == fwd_rd) q[i].b = fwd_data;
        end
      end
      if (acc) begin
        n.ctrl = in_alu_ctrl; n.a = in_src_a; n.b = in_src_b;
        n.rs1 = in_rs1; n.rs2 = in_rs2; n.rd = in_rd; n.we = in_we;
        if (fwd_valid && in_rs1 == fwd_rd) n.a = fwd_data;
        if (fwd_valid && in_rs2 == fwd_rd) n.b = fwd_data;
        q.push_back(n);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (alu_ctrl !== 5'd0 || out_rd !== 3'd0 || out_we !== 1'b0) begin fails++; $display("FAIL reset_ctrl: got ctrl=%h rd=%h we=%b want 0", alu_ctrl, out_rd, out_we); end
    checks++; if (src_A !== 48'd0 || src_B !== 48'd0) begin fails++; $display("FAIL reset_operands: got a=%h b=%h want 0", src_A, src_B); end
    rst_n = 1'b1;
    q.delete();
    @(negedge clk);
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive_in(1'b1, 5'd1, 48'h010203040506, 48'h010101010101, 3'd1, 3'd2, 3'd4, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    checks++; if (alu_ctrl !== 5'd1 || out_rd !== 3'd4 || out_we !== 1'b1) begin fails++; $display("FAIL basic_ctrl: got ctrl=%h rd=%h we=%b want 1/4/1", alu_ctrl, out_rd, out_we); end
    checks++; if (src_A !== 48'h010203040506 || src_B !== 48'h010101010101) begin fails++; $display("FAIL basic_operands: got a=%h b=%h", src_A, src_B); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
    drive_in(1'b0, 5'd0, 48'd0, 48'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back_stall();
    out_ready = 1'b0;
    drive_in(1'b1, 5'd2, 48'h111111111111, 48'h1, 3'd0, 3'd0, 3'd1, 1'b1);
    tick();
    checks++; if (in_ready !== 1'b1 || alu_ctrl !== 5'd2) begin fails++; $display("FAIL stall_c1: got ready=%b ctrl=%h want 1/2", in_ready, alu_ctrl); end
    drive_in(1'b1, 5'd3, 48'h222222222222, 48'h2, 3'd0, 3'd0, 3'd2, 1'b1);
    tick();
    checks++; if (in_ready !== 1'b0 || alu_ctrl !== 5'd2) begin fails++; $display("FAIL stall_c2: got ready=%b ctrl=%h want 0/2", in_ready, alu_ctrl); end
    drive_in(1'b1, 5'd4, 48'h333333333333, 48'h3, 3'd0, 3'd0, 3'd3, 1'b1);
    tick();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || src_A !== 48'h111111111111) begin fails++; $display("FAIL stall_c3: got ready=%b valid=%b a=%h", in_ready, out_valid, src_A); end
    out_ready = 1'b1;
    tick();
    checks++; if (alu_ctrl !== 5'd3 || src_A !== 48'h222222222222 || in_ready !== 1'b1) begin fails++; $display("FAIL stall_second: got ctrl=%h a=%h ready=%b want 3", alu_ctrl, src_A, in_ready); end
    tick();
    checks++; if (alu_ctrl !== 5'd4 || src_A !== 48'h333333333333 || out_valid !== 1'b1) begin fails++; $display("FAIL stall_third: got ctrl=%h a=%h valid=%b want 4", alu_ctrl, src_A, out_valid); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_no_dup: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_fwd_capture();
    out_ready = 1'b1;
    fwd_valid = 1'b1; fwd_rd = 3'd3; fwd_data = 48'hAAAAAAAAAAAA;
    drive_in(1'b1, 5'd5, 48'h0F0F0F0F0F0F, 48'h0E0E0E0E0E0E, 3'd3, 3'd4, 3'd5, 1'b0);
    tick();
    checks++; if (src_A !== 48'hAAAAAAAAAAAA || src_B !== 48'h0E0E0E0E0E0E) begin fails++; $display("FAIL fwd_cap_a: got a=%h b=%h", src_A, src_B); end
    drive_in(1'b1, 5'd6, 48'h0F0F0F0F0F0F, 48'h0E0E0E0E0E0E, 3'd3, 3'd3, 3'd5, 1'b0);
    tick();
    checks++; if (src_A !== 48'hAAAAAAAAAAAA || src_B !== 48'hAAAAAAAAAAAA) begin fails++; $display("FAIL fwd_cap_both: got a=%h b=%h", src_A, src_B); end
    fwd_valid = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_fwd_held();
    out_ready = 1'b0;
    drive_in(1'b1, 5'd7, 48'h000000000007, 48'h000000000008, 3'd0, 3'd1, 3'd2, 1'b1);
    tick();
    drive_in(1'b1, 5'd8, 48'h0000000000A0, 48'h0000000000B0, 3'd6, 3'd5, 3'd7, 1'b1);
    tick();
    in_valid = 1'b0;
    fwd_valid = 1'b1; fwd_rd = 3'd5; fwd_data = 48'h123456789ABC;
    tick();
    fwd_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (src_B !== 48'h000000000008) begin fails++; $display("FAIL fwd_held_main: got b=%h want 000000000008", src_B); end
    tick();
    checks++; if (alu_ctrl !== 5'd8 || src_B !== 48'h123456789ABC || src_A !== 48'h0000000000A0) begin fails++; $display("FAIL fwd_held_skid: got ctrl=%h a=%h b=%h", alu_ctrl, src_A, src_B); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_in(1'b1, 5'd9, 48'h9, 48'h9, 3'd0, 3'd0, 3'd1, 1'b1);
    tick();
    drive_in(1'b1, 5'd10, 48'hA, 48'hA, 3'd0, 3'd0, 3'd1, 1'b1);
    tick();
    flush = 1'b1;
    drive_in(1'b1, 5'd11, 48'hB, 48'hB, 3'd0, 3'd0, 3'd1, 1'b1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_full: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    drive_in(1'b1, 5'd12, 48'hC, 48'hC, 3'd0, 3'd0, 3'd1, 1'b1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_accept: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_output: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive_in(1'b1, 5'd13, 48'hD, 48'hD, 3'd0, 3'd0, 3'd3, 1'b1);
    tick();
    drive_in(1'b1, 5'd14, 48'hE, 48'hE, 3'd0, 3'd0, 3'd3, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL areset_pre: got valid=%b ready=%b want 1/0", out_valid, in_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL areset_flags: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    checks++; if (alu_ctrl !== 5'd0 || src_A !== 48'd0 || src_B !== 48'd0 || out_rd !== 3'd0 || out_we !== 1'b0) begin fails++; $display("FAIL areset_data: got ctrl=%h a=%h b=%h rd=%h we=%b want 0", alu_ctrl, src_A, src_B, out_rd, out_we); end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive_in(1'($urandom_range(0, 3) != 0), 5'($urandom), {$urandom, 16'($urandom)},
               {$urandom, 16'($urandom)}, 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      fwd_valid = ($urandom_range(0, 1) != 0);
      fwd_rd    = 3'($urandom);
      fwd_data  = {$urandom, 16'($urandom)};
      flush     = ($urandom_range(0, 24) == 0);
      checks++; if (out_valid !== (q.size() > 0)) begin fails++; $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, out_valid, q.size() > 0); end
      checks++; if (in_ready !== (q.size() < 2)) begin fails++; $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, in_ready, q.size() < 2); end
      if (q.size() > 0) begin
        checks++; if (alu_ctrl !== q[0].ctrl || out_rd !== q[0].rd || out_we !== q[0].we) begin fails++; $display("FAIL rand_ctrl cyc %0d: got %h/%h/%b want %h/%h/%b", cyc, alu_ctrl, out_rd, out_we, q[0].ctrl, q[0].rd, q[0].we); end
        checks++; if (src_A !== q[0].a || src_B !== q[0].b) begin fails++; $display("FAIL rand_operands cyc %0d: got a=%h b=%h want a=%h b=%h", cyc, src_A, src_B, q[0].a, q[0].b); end
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; fwd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back_stall();
    test_fwd_capture();
    test_fwd_held();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
